// File: rtl/fxp_mult_arbiter.sv
// Round-robin arbiter sharing one unpipelined fixed-point multiplier between NREQ val/rdy clients.
// Define FXP_MULT_ARB_FIXED_PRIO_EN to use fixed lowest-index priority; requester 0 may then starve the others.
module fxp_mult_arbiter #(
    parameter int n    = 32,
    parameter int d    = 16,
    parameter int NREQ = 4,
    localparam int IW  = $clog2(NREQ)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NREQ-1:0]   req_val,
    output logic [NREQ-1:0]   req_rdy,
    input  logic [NREQ*n-1:0] req_a,
    input  logic [NREQ*n-1:0] req_b,
    output logic [NREQ-1:0]   resp_val,
    input  logic [NREQ-1:0]   resp_rdy,
    output logic [n-1:0]      resp_c,
    output logic              mult_recv_val,
    input  logic              mult_recv_rdy,
    output logic [n-1:0]      mult_a,
    output logic [n-1:0]      mult_b,
    input  logic              mult_send_val,
    output logic              mult_send_rdy,
    input  logic [n-1:0]      mult_c,
    output logic              busy,
    output logic [IW-1:0]     owner
);

    if (d < 0 || d > n || NREQ < 2) begin : g_param_check
        $error("fxp_mult_arbiter: need 0 <= d <= n and NREQ >= 2");
    end

    typedef enum logic {IDLE, BUSY} state_t;

    state_t        state, state_nxt;
    logic [IW-1:0] owner_nxt;
    logic [IW-1:0] grant;
    logic          grant_vld;

`ifdef FXP_MULT_ARB_FIXED_PRIO_EN
    always_comb begin
        grant     = '0;
        grant_vld = 1'b0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (req_val[i]) begin
                grant     = IW'(i);
                grant_vld = 1'b1;
            end
        end
    end
`else
    logic [IW-1:0] ptr, ptr_nxt;

    // Search starts at ptr and wraps modulo NREQ, so non-power-of-two NREQ never leaves the valid range.
    always_comb begin
        grant     = '0;
        grant_vld = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            if (!grant_vld && req_val[(int'(ptr) + k) % NREQ]) begin
                grant     = IW'((int'(ptr) + k) % NREQ);
                grant_vld = 1'b1;
            end
        end
    end
`endif

    always_comb begin
        state_nxt     = state;
        owner_nxt     = owner;
`ifndef FXP_MULT_ARB_FIXED_PRIO_EN
        ptr_nxt       = ptr;
`endif
        req_rdy       = '0;
        resp_val      = '0;
        resp_c        = '0;
        mult_recv_val = 1'b0;
        mult_send_rdy = 1'b0;
        mult_a        = '0;
        mult_b        = '0;
        busy          = 1'b0;
        if (!reset) begin
            case (state)
                IDLE: begin
                    if (grant_vld) begin
                        mult_recv_val  = 1'b1;
                        mult_a         = req_a[int'(grant)*n +: n];
                        mult_b         = req_b[int'(grant)*n +: n];
                        req_rdy[grant] = mult_recv_rdy;
                        if (mult_recv_rdy) begin
                            owner_nxt = grant;
                            state_nxt = BUSY;
`ifndef FXP_MULT_ARB_FIXED_PRIO_EN
                            ptr_nxt   = (grant == IW'(NREQ - 1)) ? '0 : grant + IW'(1);
`endif
                        end
                    end
                end
                BUSY: begin
                    busy            = 1'b1;
                    resp_val[owner] = mult_send_val;
                    mult_send_rdy   = resp_rdy[owner];
                    resp_c          = mult_c;
                    if (mult_send_val && resp_rdy[owner])
                        state_nxt = IDLE;
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            owner <= '0;
`ifndef FXP_MULT_ARB_FIXED_PRIO_EN
            ptr   <= '0;
`endif
        end else begin
            state <= state_nxt;
            owner <= owner_nxt;
`ifndef FXP_MULT_ARB_FIXED_PRIO_EN
            ptr   <= ptr_nxt;
`endif
        end
    end

endmodule

// File: tb/tb_fxp_mult_arbiter.sv
// Directed bench for fxp_mult_arbiter with a behavioural n-cycle multiplier and a response scoreboard.
module tb_fxp_mult_arbiter;
    localparam int N    = 32;
    localparam int D    = 16;
    localparam int NREQ = 4;
    localparam int IW   = $clog2(NREQ);

    logic              clk = 1'b0;
    logic              reset;
    logic [NREQ-1:0]   req_val, req_rdy, resp_val, resp_rdy;
    logic [NREQ*N-1:0] req_a, req_b;
    logic [N-1:0]      resp_c, mult_a, mult_b, mult_c;
    logic              mult_recv_val, mult_recv_rdy, mult_send_val, mult_send_rdy, busy;
    logic [IW-1:0]     owner;

    fxp_mult_arbiter #(.n(N), .d(D), .NREQ(NREQ)) dut (
        .clk(clk), .reset(reset),
        .req_val(req_val), .req_rdy(req_rdy), .req_a(req_a), .req_b(req_b),
        .resp_val(resp_val), .resp_rdy(resp_rdy), .resp_c(resp_c),
        .mult_recv_val(mult_recv_val), .mult_recv_rdy(mult_recv_rdy),
        .mult_a(mult_a), .mult_b(mult_b),
        .mult_send_val(mult_send_val), .mult_send_rdy(mult_send_rdy), .mult_c(mult_c),
        .busy(busy), .owner(owner)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [N-1:0] fxmul(logic [N-1:0] a, logic [N-1:0] b);
        longint p;
        p = longint'($signed(a)) * longint'($signed(b));
        p = p >>> D;
        return p[N-1:0];
    endfunction

    // Iterative multiplier model: IDLE -> N calc cycles -> DONE (held until send handshake).
    logic [1:0]   m_st;
    int           m_cnt;
    logic [N-1:0] m_res;
    assign mult_recv_rdy = (m_st == 2'd0);
    assign mult_send_val = (m_st == 2'd2);
    assign mult_c        = m_res;
    always @(posedge clk) begin
        if (reset) begin
            m_st  <= 2'd0;
            m_cnt <= 0;
            m_res <= '0;
        end else begin
            case (m_st)
                2'd0: if (mult_recv_val) begin
                    m_st  <= 2'd1;
                    m_cnt <= N;
                    m_res <= fxmul(mult_a, mult_b);
                end
                2'd1: begin
                    m_cnt <= m_cnt - 1;
                    if (m_cnt == 1) m_st <= 2'd2;
                end
                2'd2: if (mult_send_rdy) m_st <= 2'd0;
                default: m_st <= 2'd0;
            endcase
        end
    end

    typedef struct {
        int           idx;
        logic [N-1:0] prod;
        int           t;
    } exp_t;

    exp_t sb[$];
    int   grant_log[$];
    int   model_ptr = 0;
    bit   first_seen = 0;
    int   mg, og;
    logic [NREQ-1:0] er;
    exp_t e;

    function automatic int model_grant(logic [NREQ-1:0] v, int p);
`ifdef FXP_MULT_ARB_FIXED_PRIO_EN
        for (int i = 0; i < NREQ; i++) if (v[i]) return i;
`else
        for (int k = 0; k < NREQ; k++) if (v[(p + k) % NREQ]) return (p + k) % NREQ;
`endif
        return -1;
    endfunction

    always @(negedge clk) begin
        if (reset) begin
            model_ptr  = 0;
            first_seen = 0;
            sb.delete();
        end else begin
            if (mult_recv_val && mult_recv_rdy) begin
                mg = model_grant(req_val, model_ptr);
                er = '0;
                if (mg >= 0) er[mg] = 1'b1;
                check("grant_rdy", req_rdy, er);
                og = -1;
                for (int i = 0; i < NREQ; i++) if (req_rdy[i]) og = i;
                grant_log.push_back(og);
                if (mg >= 0) begin
                    check("fwd_a", mult_a, req_a[mg*N +: N]);
                    e.idx  = mg;
                    e.prod = fxmul(req_a[mg*N +: N], req_b[mg*N +: N]);
                    e.t    = cyc;
                    sb.push_back(e);
                    model_ptr = (mg + 1) % NREQ;
                end
            end
            if ((|resp_val) && !first_seen && sb.size() > 0) begin
                check("latency", cyc - sb[0].t, N + 1);
                first_seen = 1;
            end
            if (|(resp_val & resp_rdy)) begin
                if (sb.size() == 0) begin
                    check("unexpected_resp", resp_val, 0);
                end else begin
                    e  = sb.pop_front();
                    er = '0;
                    er[e.idx] = 1'b1;
                    check("resp_val", resp_val, er);
                    check("resp_c", resp_c, e.prod);
                    first_seen = 0;
                end
            end
        end
    end

    task automatic send(int i, logic [N-1:0] a, logic [N-1:0] b);
        bit ok;
        ok = 0;
        req_a[i*N +: N] = a;
        req_b[i*N +: N] = b;
        req_val[i] = 1'b1;
        for (int c = 0; c < 200 && !ok; c++) begin
            @(negedge clk);
            if (req_rdy[i]) ok = 1;
        end
        check("accept_timeout", ok, 1);
        @(posedge clk); #1;
        req_val[i] = 1'b0;
    endtask

    task automatic wait_resp(int i, logic [N-1:0] exp);
        bit ok;
        logic [NREQ-1:0] ev;
        ok = 0;
        ev = '0;
        ev[i] = 1'b1;
        for (int c = 0; c < 200 && !ok; c++) begin
            @(negedge clk);
            if (resp_val[i]) ok = 1;
        end
        check("resp_timeout", ok, 1);
        check("resp_c_const", resp_c, exp);
        check("resp_onehot", resp_val, ev);
    endtask

    task automatic drain();
        bit ok;
        ok = 0;
        for (int c = 0; c < 400 && !ok; c++) begin
            @(negedge clk); #1;
            if (sb.size() == 0 && !busy) ok = 1;
        end
        check("drain_timeout", ok, 1);
        @(posedge clk); #1;
    endtask

    task automatic wait_grants(int cnt);
        bit ok;
        ok = 0;
        for (int c = 0; c < 1000 && !ok; c++) begin
            @(negedge clk); #1;
            if (grant_log.size() >= cnt) ok = 1;
        end
        check("grant_timeout", ok, 1);
        @(posedge clk); #1;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit seen;
        int exp_rr[5];
        exp_rr = '{0, 1, 2, 3, 0};
        reset = 1'b1; req_val = '1; resp_rdy = '0; req_a = '0; req_b = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_req_rdy", req_rdy, 0);
        check("rst_resp_val", resp_val, 0);
        check("rst_recv_val", mult_recv_val, 0);
        check("rst_send_rdy", mult_send_rdy, 0);
        check("rst_busy", busy, 0);
        check("rst_owner", owner, 0);
        @(posedge clk); #1;
        reset = 1'b0; req_val = '0; resp_rdy = '1;
        @(negedge clk);
        check("idle_recv_val", mult_recv_val, 0);
        check("idle_mult_a", mult_a, 0);
        check("idle_busy", busy, 0);

        // single op from requester 0
        send(0, 32'h0001_8000, 32'h0002_0000);
        check("single_busy", busy, 1);
        check("single_owner", owner, 0);
        wait_resp(0, 32'h0003_0000);
        drain();

        // signed op from requester 2
        send(2, 32'hFFFE_8000, 32'h0002_0000);
        wait_resp(2, 32'hFFFD_0000);
        check("signed_owner", owner, 2);
        drain();

        // all requesters continuously valid after reset
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        grant_log.delete();
        for (int i = 0; i < NREQ; i++) begin
            req_a[i*N +: N] = N'((i + 1) << 16);
            req_b[i*N +: N] = N'((i + 3) << 15);
        end
        req_val = '1;
        wait_grants(5);
        req_val = '0;
        drain();
        for (int i = 0; i < 5; i++) begin
`ifdef FXP_MULT_ARB_FIXED_PRIO_EN
            check("fixed_order", grant_log[i], 0);
`else
            check("rr_order", grant_log[i], exp_rr[i]);
`endif
        end

`ifdef FXP_MULT_ARB_FIXED_PRIO_EN
        grant_log.delete();
        req_val = 4'b0101;
        wait_grants(3);
        req_val[0] = 1'b0;
        wait_grants(4);
        req_val = '0;
        drain();
        check("fixed_starve", grant_log[0] + grant_log[1] + grant_log[2], 0);
        check("fixed_next", grant_log[3], 2);
`endif

        // backpressure on requester 3 with requester 1 waiting
        resp_rdy[3] = 1'b0;
        send(3, 32'h0005_0000, 32'hFFFF_0000);
        req_a[1*N +: N] = 32'h0000_8000;
        req_b[1*N +: N] = 32'h0000_8000;
        req_val[1] = 1'b1;
        wait_resp(3, 32'hFFFB_0000);
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            check("bp_resp_val", resp_val, 4'b1000);
            check("bp_resp_c", resp_c, 32'hFFFB_0000);
            check("bp_req_rdy", req_rdy, 0);
        end
        @(posedge clk); #1;
        resp_rdy[3] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("bp_next_grant", req_rdy, 4'b0010);
        @(posedge clk); #1;
        req_val[1] = 1'b0;
        wait_resp(1, 32'h0000_4000);
        drain();

        // reset in the middle of an operation
        send(2, 32'h0003_0000, 32'h0003_0000);
        repeat (10) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        check("midrst_busy", busy, 0);
        check("midrst_owner", owner, 0);
        seen = 0;
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            if (|resp_val) seen = 1;
        end
        check("midrst_no_resp", seen, 0);
        req_a[1*N +: N] = 32'h0002_0000;
        req_b[1*N +: N] = 32'h0002_8000;
        req_a[3*N +: N] = 32'h0001_0000;
        req_b[3*N +: N] = 32'h0007_0000;
        @(posedge clk); #1;
        req_val = 4'b1010;
        @(negedge clk);
        check("midrst_grant", req_rdy, 4'b0010);
        @(posedge clk); #1;
        req_val = '0;
        wait_resp(1, 32'h0005_0000);
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
